// File: rtl/pipe_mem_arbiter_if.sv
// pipe_mem_arbiter_if: request/grant bundle between the pipe_MIPS32 core ports
// (fetch, data, loader), the arbiter, and the single-port memory.
//   master : environment side (core stages, loader, memory read data)
//   slave  : arbiter side (grants, read returns, memory command, fetch stall)
interface pipe_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          halted;
    // fetch port (read-only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // data port
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    // loader/debug port
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    // memory command / return
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          fetch_stall;

    modport master (
        output halted,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  fetch_stall
    );

    modport slave (
        input  halted,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output fetch_stall
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one synchronous single-port memory between the IF
// fetch port, the MEM data port and a loader port usable only while halted.
// Ports:
//   clk1 - clock (rising edge)      rst - async active-high reset
//   bus  - pipe_mem_arbiter_if.slave: per-port req/gnt, read returns,
//          memory command, fetch_stall
// Grants are combinational (transfer completes in the grant cycle); read data
// returns one cycle later straight from mem_rdata, and is held afterwards.
module pipe_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk1,
    input  logic                  rst,
    pipe_mem_arbiter_if.slave     bus
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} mode_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_LD} own_t;

    mode_t         mode;
    own_t          owner;
    logic [3:0]    starve_cnt;
    logic [DW-1:0] if_rd_q, dm_rd_q, ld_rd_q;
    logic          g_if, g_dm, g_ld;

    // One winner per cycle. No grants while reset is held so nothing reaches
    // memory before the mode/owner state is valid.
    always_comb begin
        g_if = 1'b0;
        g_dm = 1'b0;
        g_ld = 1'b0;
        if (!rst) begin
            case (mode)
                RUN: begin
                    if (bus.if_req && starve_cnt == SMAX) g_if = 1'b1;
                    else if (bus.dm_req)                  g_dm = 1'b1;
                    else if (bus.if_req)                  g_if = 1'b1;
                end
                LOAD:    g_ld = bus.ld_req;
                default: ;  // DRAIN: let the in-flight read return, grant nothing
            endcase
        end
    end

    always_comb begin
        bus.mem_en    = g_if | g_dm | g_ld;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (g_if) begin
            bus.mem_addr  = bus.if_addr;
        end else if (g_dm) begin
            bus.mem_we    = bus.dm_we;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
        end else if (g_ld) begin
            bus.mem_we    = bus.ld_we;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
        end
    end

    assign bus.if_gnt      = g_if;
    assign bus.dm_gnt      = g_dm;
    assign bus.ld_gnt      = g_ld;
    assign bus.fetch_stall = bus.if_req & ~g_if;

    // Return cycle: owner's rdata passes mem_rdata through, otherwise the
    // last captured word is held.
    assign bus.if_rvalid = (owner == OWN_IF);
    assign bus.dm_rvalid = (owner == OWN_DM);
    assign bus.ld_rvalid = (owner == OWN_LD);
    assign bus.if_rdata  = (owner == OWN_IF) ? bus.mem_rdata : if_rd_q;
    assign bus.dm_rdata  = (owner == OWN_DM) ? bus.mem_rdata : dm_rd_q;
    assign bus.ld_rdata  = (owner == OWN_LD) ? bus.mem_rdata : ld_rd_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mode       <= RUN;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            if_rd_q    <= '0;
            dm_rd_q    <= '0;
            ld_rd_q    <= '0;
        end else begin
            case (mode)
                RUN:     if (bus.halted && bus.ld_req) mode <= DRAIN;
                DRAIN:   mode <= bus.halted ? LOAD : RUN;
                LOAD:    if (!bus.halted) mode <= RUN;
                default: mode <= RUN;
            endcase

            if (mode == RUN) begin
                if (bus.if_req && !g_if)
                    starve_cnt <= (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
                else
                    starve_cnt <= '0;
            end

            if (owner == OWN_IF) if_rd_q <= bus.mem_rdata;
            if (owner == OWN_DM) dm_rd_q <= bus.mem_rdata;
            if (owner == OWN_LD) ld_rd_q <= bus.mem_rdata;

            if (g_if)                    owner <= OWN_IF;
            else if (g_dm && !bus.dm_we) owner <= OWN_DM;
            else if (g_ld && !bus.ld_we) owner <= OWN_LD;
            else                         owner <= OWN_NONE;
        end
    end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Bench for pipe_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level reference model of the arbiter
// rules and a behavioural memory.
module tb_pipe_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int DEPTH = 1 << AW;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    pipe_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    pipe_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.slave)
    );

    // Synchronous memory device
    logic [DW-1:0] dev_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) dev_mem[i] = 32'(i * 3 + 7);
        dev_mem[0] = 32'h2801000a;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk1);
            if (bus.mem_en) begin
                if (bus.mem_we) dev_mem[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata <= dev_mem[bus.mem_addr];
            end
        end
    end

    // Reference model: mode 0=RUN 1=DRAIN 2=LOAD; port 0=none 1=if 2=dm 3=ld
    logic [DW-1:0] ref_mem [DEPTH];
    int            r_mode, r_starve, r_pend;
    logic [DW-1:0] r_pdata;
    logic [DW-1:0] r_held [4];

    int checks = 0;
    int errors = 0;

    logic          ob_if_gnt, ob_dm_gnt, ob_ld_gnt, ob_stall;
    logic          ob_if_rv, ob_dm_rv, ob_ld_rv;
    logic [DW-1:0] ob_if_rd, ob_dm_rd, ob_ld_rd;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        r_mode   = 0;
        r_starve = 0;
        r_pend   = 0;
        r_pdata  = '0;
        for (int p = 0; p < 4; p++) r_held[p] = '0;
    endtask

    // One clock cycle: inputs already set just after the previous edge.
    task automatic step(input string tag);
        int            win;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        #3;
        win = 0;
        if (!rst) begin
            if (r_mode == 0) begin
                if (bus.if_req && r_starve >= SM) win = 1;
                else if (bus.dm_req)              win = 2;
                else if (bus.if_req)              win = 1;
            end else if (r_mode == 2 && bus.ld_req) win = 3;
        end
        ewe = 1'b0; ea = '0; ew = '0;
        case (win)
            1: ea = bus.if_addr;
            2: begin ewe = bus.dm_we; ea = bus.dm_addr; ew = bus.dm_wdata; end
            3: begin ewe = bus.ld_we; ea = bus.ld_addr; ew = bus.ld_wdata; end
            default: ;
        endcase
        ob_if_gnt = bus.if_gnt;    ob_dm_gnt = bus.dm_gnt;    ob_ld_gnt = bus.ld_gnt;
        ob_stall  = bus.fetch_stall;
        ob_if_rv  = bus.if_rvalid; ob_dm_rv  = bus.dm_rvalid; ob_ld_rv  = bus.ld_rvalid;
        ob_if_rd  = bus.if_rdata;  ob_dm_rd  = bus.dm_rdata;  ob_ld_rd  = bus.ld_rdata;
        chk({tag, ".if_gnt"},      32'(ob_if_gnt), 32'(win == 1));
        chk({tag, ".dm_gnt"},      32'(ob_dm_gnt), 32'(win == 2));
        chk({tag, ".ld_gnt"},      32'(ob_ld_gnt), 32'(win == 3));
        chk({tag, ".fetch_stall"}, 32'(ob_stall),  32'(bus.if_req && win != 1));
        chk({tag, ".mem_en"},      32'(bus.mem_en), 32'(win != 0));
        chk({tag, ".mem_we"},      32'(bus.mem_we), 32'(ewe));
        chk({tag, ".mem_addr"},    32'(bus.mem_addr), 32'(ea));
        chk({tag, ".mem_wdata"},   bus.mem_wdata, ew);
        chk({tag, ".if_rvalid"},   32'(ob_if_rv), 32'(r_pend == 1));
        chk({tag, ".dm_rvalid"},   32'(ob_dm_rv), 32'(r_pend == 2));
        chk({tag, ".ld_rvalid"},   32'(ob_ld_rv), 32'(r_pend == 3));
        chk({tag, ".if_rdata"},    ob_if_rd, (r_pend == 1) ? r_pdata : r_held[1]);
        chk({tag, ".dm_rdata"},    ob_dm_rd, (r_pend == 2) ? r_pdata : r_held[2]);
        chk({tag, ".ld_rdata"},    ob_ld_rd, (r_pend == 3) ? r_pdata : r_held[3]);
        @(posedge clk1);
        if (!rst) begin
            if (r_pend != 0) r_held[r_pend] = r_pdata;
            r_pend = 0;
            if (win != 0) begin
                if (ewe) ref_mem[ea] = ew;
                else begin r_pend = win; r_pdata = ref_mem[ea]; end
            end
            if (r_mode == 0)
                r_starve = (bus.if_req && win != 1) ? ((r_starve < SM) ? r_starve + 1 : SM) : 0;
            case (r_mode)
                0: if (bus.halted && bus.ld_req) r_mode = 1;
                1: r_mode = bus.halted ? 2 : 0;
                2: if (!bus.halted) r_mode = 0;
                default: r_mode = 0;
            endcase
        end
        #1;
    endtask

    task automatic idle();
        bus.if_req = 0; bus.dm_req = 0; bus.ld_req = 0;
        bus.dm_we  = 0; bus.ld_we  = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i * 3 + 7);
        ref_mem[0] = 32'h2801000a;
        bus.halted = 0;
        bus.if_addr = '0; bus.dm_addr = '0; bus.ld_addr = '0;
        bus.dm_wdata = '0; bus.ld_wdata = '0;
        idle();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk1);
        #1;
        step("reset");
        rst = 0;

        // Basic fetch
        bus.if_req = 1; bus.if_addr = 0;
        step("fetch0");
        chk("fetch.gnt", 32'(ob_if_gnt), 32'd1);
        chk("fetch.stall", 32'(ob_stall), 32'd0);
        idle();
        step("fetch1");
        chk("fetch.rvalid", 32'(ob_if_rv), 32'd1);
        chk("fetch.rdata", ob_if_rd, 32'h2801000a);

        // Reset with a fetch read granted in the same cycle
        bus.if_req = 1; bus.if_addr = 5;
        #3;
        chk("rstmid.gnt", 32'(bus.if_gnt), 32'd1);
        #1;
        rst = 1;
        model_reset();
        idle();
        @(posedge clk1);
        #1;
        chk("rstmid.rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rstmid.rdata", bus.if_rdata, 32'd0);
        rst = 0;
        bus.if_req = 1; bus.if_addr = 0;
        step("rstmid.run");
        chk("rstmid.run_gnt", 32'(ob_if_gnt), 32'd1);
        idle();
        step("rstmid.tail");

        // Priority and starvation
        bus.if_req = 1; bus.if_addr = 1;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 3;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("starve%0d", i));
            chk($sformatf("starve%0d.if", i), 32'(ob_if_gnt), 32'(i == 4));
            chk($sformatf("starve%0d.dm", i), 32'(ob_dm_gnt), 32'(i != 4));
            chk($sformatf("starve%0d.stall", i), 32'(ob_stall), 32'(i != 4));
        end
        idle();
        step("starve.tail");

        // Data write then read-after-write
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 20; bus.dm_wdata = 32'h0000001e;
        step("dmwr");
        bus.dm_we = 0;
        step("dmrd");
        chk("dmwr.no_rvalid", 32'(ob_dm_rv), 32'd0);
        idle();
        step("dmret");
        chk("dmrd.rvalid", 32'(ob_dm_rv), 32'd1);
        chk("dmrd.rdata", ob_dm_rd, 32'h0000001e);

        // Loader entry and exit
        bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 8; bus.ld_wdata = 32'hfc000000;
        step("ld.nohalt");
        chk("ld.nohalt_gnt", 32'(ob_ld_gnt), 32'd0);
        bus.halted = 1;
        step("ld.enter");
        chk("ld.enter_gnt", 32'(ob_ld_gnt), 32'd0);
        step("ld.drain");
        chk("ld.drain_gnt", 32'(ob_ld_gnt), 32'd0);
        step("ld.wr");
        chk("ld.wr_gnt", 32'(ob_ld_gnt), 32'd1);
        bus.ld_we = 0;
        step("ld.rd");
        bus.ld_req = 0; bus.if_req = 1; bus.if_addr = 0;
        step("ld.ret");
        chk("ld.rvalid", 32'(ob_ld_rv), 32'd1);
        chk("ld.rdata", ob_ld_rd, 32'hfc000000);
        chk("ld.fetch_stall", 32'(ob_stall), 32'd1);
        bus.halted = 0;
        step("ld.exit");
        chk("ld.exit_ifgnt", 32'(ob_if_gnt), 32'd0);
        step("ld.run");
        chk("ld.run_ifgnt", 32'(ob_if_gnt), 32'd1);
        idle();
        step("ld.tail");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) bus.halted = ~bus.halted;
            bus.if_req   = 1'($urandom_range(0, 1));
            bus.if_addr  = AW'($urandom_range(0, 15));
            bus.dm_req   = ($urandom_range(0, 2) == 0);
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_addr  = AW'($urandom_range(0, 15));
            bus.dm_wdata = $urandom;
            bus.ld_req   = 1'($urandom_range(0, 1));
            bus.ld_we    = 1'($urandom_range(0, 1));
            bus.ld_addr  = AW'($urandom_range(0, 15));
            bus.ld_wdata = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1;
                model_reset();
                step($sformatf("rnd%0d.rst", n));
                rst = 0;
            end else begin
                step($sformatf("rnd%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
